// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO access-control slice.
package fifo_pkg;

    localparam int unsigned DEF_ADDR_W     = 4;
    localparam int unsigned DEF_AFULL_LVL  = 12;
    localparam int unsigned DEF_AEMPTY_LVL = 2;

    // The occupancy counter needs one bit more than the pointers to represent a full FIFO.
    function automatic int unsigned count_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    typedef enum logic {
        WselReq0 = 1'b0,
        WselReq1 = 1'b1
    } wsel_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin write arbiter; priority moves only on an accepted write.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rest,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    // Last-winner state held as the requester favoured on the next tie (the last loser).
    // Resets to 0 so requester 0 wins the first tie.
    logic prio_q, prio_d;

    // Grant decode and priority update.
    always_comb begin
        o_gnt  = 2'b00;
        prio_d = prio_q;
        if (i_accept) begin
            unique case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = prio_q ? 2'b10 : 2'b01;
                default: o_gnt = 2'b00;
            endcase
        end
        if (o_gnt != 2'b00) begin
            prio_d = o_gnt[0];
        end
    end

    // Priority register.
    always_ff @(posedge i_clk or negedge i_rest) begin
        if (!i_rest) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/fifo_access_control.sv
// FIFO pointer, occupancy and arbitration control around an external dual-port RAM.
module fifo_access_control
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned AFULL_LVL  = DEF_AFULL_LVL,
    parameter int unsigned AEMPTY_LVL = DEF_AEMPTY_LVL
) (
    input  logic              i_clk,
    input  logic              i_rest,
    input  logic              i_wen0,
    input  logic              i_wen1,
    input  logic              i_ren,
    input  logic              i_clr_err,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_ram_wen,
    output logic [ADDR_W-1:0] o_ram_waddr,
    output logic              o_ram_ren,
    output logic [ADDR_W-1:0] o_ram_raddr,
    output logic              o_wsel,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_afull,
    output logic              o_aempty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_ovf,
    output logic              o_udf
);

    localparam int unsigned CNT_W = count_w(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(2 ** ADDR_W);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] CNT_AEMPT = CNT_W'(AEMPTY_LVL);

    logic [ADDR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full_q, empty_q, afull_q, aempty_q;
    logic              full_d, empty_d, afull_d, aempty_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic [1:0]        req, gnt;
    logic              wr_acc, rd_acc;
    wsel_e             wsel;

    assign req = {i_wen1, i_wen0};

    // Reset gates acceptance so no grant or strobe escapes while reset is held.
    rr_arb2 u_arb (
        .i_clk    (i_clk),
        .i_rest   (i_rest),
        .i_req    (req),
        .i_accept (~full_q & i_rest),
        .o_gnt    (gnt)
    );

    assign wr_acc = gnt[0] | gnt[1];
    assign rd_acc = i_ren & ~empty_q & i_rest;
    assign wsel   = gnt[1] ? WselReq1 : WselReq0;

    assign o_gnt0      = gnt[0];
    assign o_gnt1      = gnt[1];
    assign o_ram_wen   = wr_acc;
    assign o_ram_waddr = wptr_q;
    assign o_ram_ren   = rd_acc;
    assign o_ram_raddr = rptr_q;
    assign o_wsel      = wsel;
    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_afull     = afull_q;
    assign o_aempty    = aempty_q;
    assign o_count     = cnt_q;
    assign o_ovf       = ovf_q;
    assign o_udf       = udf_q;

    // Next occupancy and flags derived from it, so flags line up with the count.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d   = (cnt_d == CNT_FULL);
        empty_d  = (cnt_d == '0);
        afull_d  = (cnt_d >= CNT_AFULL);
        aempty_d = (cnt_d <= CNT_AEMPT);
    end

    // Sticky errors: any write request while full, or read while empty; set beats clear.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if ((i_wen0 | i_wen1) & full_q) begin
            ovf_d = 1'b1;
        end else if (i_clr_err) begin
            ovf_d = 1'b0;
        end
        if (i_ren & empty_q) begin
            udf_d = 1'b1;
        end else if (i_clr_err) begin
            udf_d = 1'b0;
        end
    end

    // Pointer, count, flag and error state.
    always_ff @(posedge i_clk or negedge i_rest) begin
        if (!i_rest) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_q <= wptr_q + ADDR_W'(1);
            end
            if (rd_acc) begin
                rptr_q <= rptr_q + ADDR_W'(1);
            end
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

endmodule

// File: tb/tb_fifo_access_control.sv
// Directed bench for fifo_access_control with a queue-level occupancy model.
module tb_fifo_access_control;

    localparam int DEPTH = 16;

    logic       i_clk, i_rest, i_wen0, i_wen1, i_ren, i_clr_err;
    logic       o_gnt0, o_gnt1, o_ram_wen, o_ram_ren, o_wsel;
    logic [3:0] o_ram_waddr, o_ram_raddr;
    logic       o_full, o_empty, o_afull, o_aempty, o_ovf, o_udf;
    logic [4:0] o_count;

    int n_chk = 0;
    int n_err = 0;

    fifo_access_control dut (
        .i_clk       (i_clk),
        .i_rest      (i_rest),
        .i_wen0      (i_wen0),
        .i_wen1      (i_wen1),
        .i_ren       (i_ren),
        .i_clr_err   (i_clr_err),
        .o_gnt0      (o_gnt0),
        .o_gnt1      (o_gnt1),
        .o_ram_wen   (o_ram_wen),
        .o_ram_waddr (o_ram_waddr),
        .o_ram_ren   (o_ram_ren),
        .o_ram_raddr (o_ram_raddr),
        .o_wsel      (o_wsel),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_afull     (o_afull),
        .o_aempty    (o_aempty),
        .o_count     (o_count),
        .o_ovf       (o_ovf),
        .o_udf       (o_udf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model state: occupancy, write/read positions, tie-break preference, sticky errors.
    int m_cnt, m_wp, m_rp, m_pref;
    bit m_ovf, m_udf;

    function automatic bit e_full();  return m_cnt == DEPTH; endfunction
    function automatic bit e_empty(); return m_cnt == 0;     endfunction
    function automatic bit e_wacc();
        return i_rest && (i_wen0 || i_wen1) && !e_full();
    endfunction
    function automatic bit e_g0();
        return e_wacc() && i_wen0 && (!i_wen1 || m_pref == 0);
    endfunction
    function automatic bit e_g1();
        return e_wacc() && !e_g0();
    endfunction
    function automatic bit e_rd();
        return i_rest && i_ren && !e_empty();
    endfunction

    // Model update.
    always @(posedge i_clk or negedge i_rest) begin
        if (!i_rest) begin
            m_cnt <= 0; m_wp <= 0; m_rp <= 0; m_pref <= 0; m_ovf <= 0; m_udf <= 0;
        end else begin
            m_cnt <= m_cnt + int'(e_wacc()) - int'(e_rd());
            m_wp  <= (m_wp + int'(e_wacc())) % DEPTH;
            m_rp  <= (m_rp + int'(e_rd())) % DEPTH;
            if (e_wacc()) m_pref <= e_g0() ? 1 : 0;
            if ((i_wen0 || i_wen1) && e_full()) m_ovf <= 1;
            else if (i_clr_err) m_ovf <= 0;
            if (i_ren && e_empty()) m_udf <= 1;
            else if (i_clr_err) m_udf <= 0;
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge i_clk) begin
        chk("gnt0",   int'(o_gnt0),      int'(e_g0()));
        chk("gnt1",   int'(o_gnt1),      int'(e_g1()));
        chk("ramwen", int'(o_ram_wen),   int'(e_wacc()));
        chk("wsel",   int'(o_wsel),      int'(e_g1()));
        chk("ramren", int'(o_ram_ren),   int'(e_rd()));
        chk("waddr",  int'(o_ram_waddr), m_wp);
        chk("raddr",  int'(o_ram_raddr), m_rp);
        chk("count",  int'(o_count),     m_cnt);
        chk("full",   int'(o_full),      int'(e_full()));
        chk("empty",  int'(o_empty),     int'(e_empty()));
        chk("afull",  int'(o_afull),     int'(m_cnt >= 12));
        chk("aempty", int'(o_aempty),    int'(m_cnt <= 2));
        chk("ovf",    int'(o_ovf),       int'(m_ovf));
        chk("udf",    int'(o_udf),       int'(m_udf));
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_wen0 = 0; i_wen1 = 0; i_ren = 0; i_clr_err = 0;
    endtask

    initial begin
        i_rest = 0; idle();
        i_wen0 = 1;
        #7;
        chk("rst_gnt0",   int'(o_gnt0),   0);
        chk("rst_ramwen", int'(o_ram_wen), 0);
        chk("rst_count",  int'(o_count),  0);
        chk("rst_empty",  int'(o_empty),  1);
        chk("rst_aempty", int'(o_aempty), 1);
        chk("rst_full",   int'(o_full),   0);
        idle();
        @(negedge i_clk);
        #1 i_rest = 1;

        // Fill from requester 0.
        for (int i = 0; i < 16; i++) begin
            i_wen0 = 1;
            #1;
            chk("fill_waddr", int'(o_ram_waddr), i);
            chk("fill_gnt0",  int'(o_gnt0), 1);
            if (i == 11) chk("afull_11", int'(o_afull), 0);
            if (i == 12) chk("afull_12", int'(o_afull), 1);
            tick();
        end
        idle();
        #1;
        chk("full_count", int'(o_count), 16);
        chk("full_flag",  int'(o_full),  1);
        chk("full_afull", int'(o_afull), 1);

        // Write and read together while full.
        i_wen0 = 1; i_ren = 1;
        #1;
        chk("wrfull_ren",  int'(o_ram_ren), 1);
        chk("wrfull_gnt0", int'(o_gnt0),    0);
        tick();
        chk("wrfull_count", int'(o_count), 15);
        chk("wrfull_ovf",   int'(o_ovf),   1);
        idle(); i_clr_err = 1;
        tick();
        chk("ovf_clr", int'(o_ovf), 0);
        idle(); i_ren = 1;
        repeat (15) tick();
        idle();
        #1;
        chk("drain_empty", int'(o_empty), 1);
        chk("drain_udf",   int'(o_udf),   0);

        // Read and write together while empty.
        i_ren = 1; i_wen1 = 1;
        #1;
        chk("wrempty_gnt1", int'(o_gnt1),    1);
        chk("wrempty_ren",  int'(o_ram_ren), 0);
        chk("wrempty_wsel", int'(o_wsel),    1);
        tick();
        chk("wrempty_count", int'(o_count), 1);
        chk("wrempty_udf",   int'(o_udf),   1);
        idle(); i_clr_err = 1;
        tick();
        chk("udf_clr", int'(o_udf), 0);
        idle(); i_ren = 1;
        tick();
        idle();

        // Both requesters from empty: alternate starting with requester 0.
        for (int i = 0; i < 4; i++) begin
            i_wen0 = 1; i_wen1 = 1;
            #1;
            chk("rr_gnt0", int'(o_gnt0), (i % 2 == 0) ? 1 : 0);
            chk("rr_wsel", int'(o_wsel), i % 2);
            tick();
        end
        idle();
        #1 chk("rr_count", int'(o_count), 4);
        i_ren = 1;
        tick();
        idle();

        // Write/read pairs at count 3 across the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            i_wen0 = 1; i_ren = 1;
            tick();
            chk("pair_count", int'(o_count), 3);
        end
        idle();
        chk("pair_waddr", int'(o_ram_waddr), 9);
        chk("pair_raddr", int'(o_ram_raddr), 6);

        // Asynchronous reset at count 9.
        i_wen0 = 1;
        repeat (6) tick();
        chk("pre_rst_count", int'(o_count), 9);
        #1 i_rest = 0;
        #1;
        chk("arst_count", int'(o_count), 0);
        chk("arst_empty", int'(o_empty), 1);
        chk("arst_gnt0",  int'(o_gnt0),  0);
        @(negedge i_clk);
        #1 i_rest = 1;
        #1;
        chk("post_rst_waddr", int'(o_ram_waddr), 0);
        chk("post_rst_gnt0",  int'(o_gnt0),      1);
        tick();
        idle();
        chk("post_rst_count", int'(o_count), 1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_access_control.md
FIFO_ACCESS_CONTROL -- requirements
Module: fifo_access_control

Interface
REQ-001 Parameter ADDR_W, default 4: RAM address width; depth = 2**ADDR_W.
REQ-002 Parameter AFULL_LVL, default 12: almost-full threshold, compared as count >= AFULL_LVL.
REQ-003 Parameter AEMPTY_LVL, default 2: almost-empty threshold, compared as count <= AEMPTY_LVL.
REQ-004 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 i_rest  in  1  asynchronous, active-low reset.
REQ-006 i_wen0  in  1  write request, requester 0.
REQ-007 i_wen1  in  1  write request, requester 1.
REQ-008 i_ren  in  1  read request.
REQ-009 i_clr_err  in  1  clears sticky error flags.
REQ-010 o_gnt0, o_gnt1  out  1 each  write grant, requesters 0/1; combinational.
REQ-011 o_ram_wen  out  1  RAM write strobe; equals o_gnt0 | o_gnt1.
REQ-012 o_ram_waddr  out  ADDR_W  RAM write address = write pointer.
REQ-013 o_ram_ren  out  1  RAM read strobe.
REQ-014 o_ram_raddr  out  ADDR_W  RAM read address = read pointer.
REQ-015 o_wsel  out  1  write-data mux select: 0 = requester 0, 1 = requester 1.
REQ-016 o_full, o_empty, o_afull, o_aempty  out  1 each  registered occupancy flags.
REQ-017 o_count  out  ADDR_W+1  registered occupancy, 0..2**ADDR_W.
REQ-018 o_ovf, o_udf  out  1 each  sticky overflow and underflow flags.

Function
REQ-019 Write accept: at most one grant per cycle, and only when o_full=0.
REQ-020 Only one requester active: that requester is granted.
REQ-021 Both requesting: round-robin grant; the requester not granted last time wins.
REQ-022 The last-winner register updates only on an accepted write.
REQ-023 Read accept: o_ram_ren = i_ren & ~o_empty.
REQ-024 Accepted write: o_ram_waddr is the current write pointer, and the write pointer increments at the clock edge.
REQ-025 Accepted read: o_ram_raddr is the current read pointer, and the read pointer increments at the clock edge.
REQ-026 RAM read data is the RAM's responsibility, one cycle after o_ram_ren.
REQ-027 Pointers wrap modulo 2**ADDR_W, with no gap or hold at the wrap.
REQ-028 Count update: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-029 Flags are registered, derived from the next count, so they are valid in the same cycle as o_count.
REQ-030 o_full = (count == 2**ADDR_W) and o_empty = (count == 0).
REQ-031 Simultaneous write and read while full: read accepted, write rejected, count goes to 2**ADDR_W-1.
REQ-032 Simultaneous write and read while empty: write accepted, read rejected, count goes to 1.
REQ-033 Simultaneous write and read otherwise: both accepted, count unchanged.
REQ-034 o_ovf sets on the next edge when any i_wenX=1 while o_full=1; losing arbitration alone does not set it.
REQ-035 o_udf sets on the next edge when i_ren=1 while o_empty=1.
REQ-036 Error flags clear when i_clr_err=1; if a set and a clear occur in the same cycle, the set wins.
REQ-037 o_wsel = 1 exactly when o_gnt1=1, and 0 otherwise.

Reset
REQ-038 While i_rest=0, all of these are 0: pointers, count, last-winner register (favours requester 0 first), o_full, o_afull, o_ovf, o_udf.
REQ-039 While i_rest=0, o_empty=1 and o_aempty=1.
REQ-040 Reset asserted mid-operation discards all FIFO contents immediately; grants and strobes are forced 0 while reset is held.
REQ-041 The first accept is possible on the first rising edge after deassertion.

Structure
REQ-042 Default ADDR_W, AFULL_LVL and AEMPTY_LVL live in the shared fifo_pkg constants, along with any width helpers.
REQ-043 The two-way round-robin arbiter is a sub-module named rr_arb2 (req[1:0], accept, gnt[1:0], last-winner state).
REQ-044 All remaining logic is flat in fifo_access_control.

Verification
REQ-045 Reset, then 16 writes from requester 0 only -> waddr 0..15; o_full=1 after the 16th edge; o_count=16; o_afull from count 12.
REQ-046 Both requesters held for 4 cycles from empty -> grants 0,1,0,1; o_wsel 0,1,0,1; o_count=4.
REQ-047 Full FIFO, i_wen0=1 and i_ren=1 together -> o_ram_ren=1, o_gnt0=0, o_count=15, o_ovf=1.
REQ-048 Empty FIFO, i_ren=1 and i_wen1=1 together -> o_gnt1=1, o_ram_ren=0, o_count=1, o_udf=1; then i_clr_err=1 -> o_udf=0.
REQ-049 20 write/read pairs at count 3 -> both pointers wrap 15 -> 0; o_count stays 3 throughout.
REQ-050 i_rest pulsed low at count 9 -> o_count=0, o_empty=1 and grants 0 asynchronously; next write uses waddr 0.
